ioctl_sram_loader: RTL

- Upstream stage of the BIOS/boot image path.
- Accepts the HPS ioctl download byte stream (ioctl_wr/ioctl_addr/ioctl_dout/ioctl_index).
- Buffers bytes in a small FIFO and writes them into the 8-bit asynchronous SRAM with programmable setup and write-pulse timing.
- Throttles the host via ioctl_wait and signals completion so the system can release the CPU from reset and let the BIOS ROM/SRAM be consumed.

---
 rtl/ioctl_sram_loader.sv | 137 +++++++++++++
 1 files changed

// File: rtl/ioctl_sram_loader.sv
// Streams HPS ioctl download bytes through a small FIFO into an 8-bit async
// SRAM, with programmable setup and write-pulse timing and host throttling.
module ioctl_sram_loader #(
  parameter int              AW           = 21,
  parameter int              DEPTH        = 4,
  parameter logic [7:0]      IDX          = 8'h00,
  parameter logic [AW-1:0]   BASE         = 21'h1FE000,
  parameter logic [24:0]     LIMIT        = 25'h2000,
  parameter int              SETUP_CYCLES = 1,
  parameter int              WE_CYCLES    = 2
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  input  logic [7:0]    ioctl_index,
  output logic          ioctl_wait,
  output logic [AW-1:0] SRAM_A,
  output logic [7:0]    SRAM_DQ_o,
  output logic          SRAM_DQ_oe,
  output logic          SRAM_WE_n,
  output logic          busy,
  output logic          done,
  output logic          overflow
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int TMAX = (SETUP_CYCLES > WE_CYCLES) ? SETUP_CYCLES : WE_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WRITE, S_HOLD} state_t;

  state_t          state, state_n;
  logic [TW-1:0]   timer, timer_n;
  logic [AW+7:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_n;
  logic [AW+7:0]   head;
  logic            accept, full, empty, push, pop;
  logic            we_n_n, oe_n, busy_n, seen;

  always_comb begin
    accept  = ioctl_wr & ioctl_download & (ioctl_index == IDX) & (ioctl_addr < LIMIT);
    full    = (count == CW'(DEPTH));
    empty   = (count == '0);
    push    = accept & ~full;
    count_n = count + CW'(push) - CW'(pop);
    head    = mem[rd_ptr];
    busy_n  = ioctl_download | ~empty | (state != S_IDLE);
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_n = state;
    timer_n = timer;
    pop     = 1'b0;
    we_n_n  = 1'b1;
    oe_n    = SRAM_DQ_oe;
    unique case (state)
      S_IDLE: if (!empty) begin
        pop     = 1'b1;
        oe_n    = 1'b1;
        timer_n = '0;
        state_n = S_SETUP;
      end
      S_SETUP: if (timer == TW'(SETUP_CYCLES - 1)) begin
        timer_n = '0;
        we_n_n  = 1'b0;
        state_n = S_WRITE;
      end else begin
        timer_n = timer + 1'b1;
      end
      S_WRITE: if (timer == TW'(WE_CYCLES - 1)) begin
        state_n = S_HOLD;
      end else begin
        timer_n = timer + 1'b1;
        we_n_n  = 1'b0;
      end
      S_HOLD: if (!empty) begin
        pop     = 1'b1;
        timer_n = '0;
        state_n = S_SETUP;
      end else begin
        oe_n    = 1'b0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // NOTE: FIFO storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr] <= {BASE + ioctl_addr[AW-1:0], ioctl_dout};
  end

  // NOTE: all state updates are non-blocking so every register samples pre-edge values.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      timer      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ioctl_wait <= 1'b0;
      SRAM_A     <= '0;
      SRAM_DQ_o  <= '0;
      SRAM_DQ_oe <= 1'b0;
      SRAM_WE_n  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      seen       <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      count      <= count_n;
      ioctl_wait <= (count_n >= CW'(DEPTH - 1));
      SRAM_WE_n  <= we_n_n;
      SRAM_DQ_oe <= oe_n;
      busy       <= busy_n;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        SRAM_A    <= head[AW+7:8];
        SRAM_DQ_o <= head[7:0];
      end
      if (accept & full) overflow <= 1'b1;
      // A completion only counts if something was accepted since the last one.
      done <= busy & ~busy_n & seen;
      seen <= accept | (seen & ~(busy & ~busy_n));
    end
  end

endmodule
